// File: rtl/mil1553_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mil1553_pkg
//  Description : Shared constants, helper functions and FSM state type for
//                the MIL-STD-1553 Manchester II receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
package mil1553_pkg;

    // Sync type codes as reported in tuser[7:5]
    localparam logic [2:0] SYNC_CMD  = 3'b100;
    localparam logic [2:0] SYNC_DATA = 3'b010;

    // tuser field positions
    localparam int TUSER_PARITY   = 0;
    localparam int TUSER_SYNC_LSB = 5;
    localparam int TUSER_SYNC_MSB = 7;

    // Half-bit rate of a 1 Mbit/s Manchester stream
    localparam int HALF_BIT_RATE       = 2_000_000;
    localparam int DEFAULT_CLOCK_SPEED = 100_000_000;

    // Clocks per half-bit for a given aclk frequency
    function automatic int hb_of(input int clock_speed);
        return clock_speed / HALF_BIT_RATE;
    endfunction

    // Shortest run accepted as one half of a sync (2.5 half-bits)
    function automatic int sync_min_of(input int hb);
        return (5 * hb) / 2;
    endfunction

    // Longest run tolerated inside a sync half (4 half-bits)
    function automatic int sync_max_of(input int hb);
        return 4 * hb;
    endfunction

    // Derived constants at the default clock
    localparam int HB       = hb_of(DEFAULT_CLOCK_SPEED);
    localparam int SYNC_MIN = sync_min_of(HB);
    localparam int SYNC_MAX = sync_max_of(HB);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC1 = 3'd1,
        ST_SYNC2 = 3'd2,
        ST_DATA  = 3'd3,
        ST_OUT   = 3'd4
    } dec_state_t;

endpackage
`default_nettype wire

// File: rtl/mil1553_bit_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : mil1553_bit_sampler
//  Description : Synchronizes the differential bus pair, tracks how long the
//                current valid symbol has been stable, and produces one
//                decision tick per half-bit at its centre. The tick phase is
//                re-aligned on every symbol transition.
//  Revision    : 1.0 - initial release
// ============================================================================
module mil1553_bit_sampler #(
    parameter int CLOCK_SPEED = 100_000_000,
    parameter int SAMPLE_RATE = 2_000_000,
    parameter int RUN_W       = 8
) (
    input  logic             aclk,
    input  logic             arstn,
    input  logic [1:0]       diff,
    output logic             symbol,
    output logic             symbol_valid,
    output logic [RUN_W-1:0] run_len,
    output logic             tick
);

    // SAMPLE_RATE grid: DIV clocks per grid step, NSLOT grid steps per half-bit
    localparam int DIV   = CLOCK_SPEED / SAMPLE_RATE;
    localparam int NSLOT = SAMPLE_RATE / 2_000_000;
    localparam int PH_W  = $clog2(DIV);
    localparam int SL_W  = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    // Half-bit centre expressed as (slot, phase) on the grid
    localparam logic [PH_W-1:0] TICK_PHASE = (NSLOT > 1) ? '0 : PH_W'(DIV / 2);
    localparam logic [SL_W-1:0] TICK_SLOT  = (NSLOT > 1) ? SL_W'(NSLOT / 2) : '0;
    localparam logic [PH_W-1:0] PH_LAST    = PH_W'(DIV - 1);
    localparam logic [SL_W-1:0] SL_LAST    = SL_W'(NSLOT - 1);

    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       sync3_q, sync3_d;
    logic             symbol_q, symbol_d;
    logic             valid_q, valid_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [SL_W-1:0]  slot_q, slot_d;
    logic             tick_q, tick_d;

    wire w_change = (sync2_q != sync3_q);
    wire w_valid  = sync2_q[1] ^ sync2_q[0];

    // Next-state: synchronizer chain, run length and grid phase
    always_comb begin
        sync1_d  = diff;
        sync2_d  = sync1_q;
        sync3_d  = sync2_q;
        symbol_d = sync2_q[1];
        valid_d  = w_valid;
        run_d    = run_q;
        phase_d  = phase_q;
        slot_d   = slot_q;
        tick_d   = 1'b0;

        // Run length restarts on any change and is held at zero while invalid
        if (w_change || !w_valid) begin
            run_d = '0;
        end else if (run_q != '1) begin
            run_d = run_q + 1'b1;
        end

        // Grid phase re-aligns to each transition so ticks track the sender
        if (w_change) begin
            phase_d = '0;
            slot_d  = '0;
        end else begin
            tick_d = (phase_q == TICK_PHASE) && (slot_q == TICK_SLOT);
            if (phase_q == PH_LAST) begin
                phase_d = '0;
                slot_d  = (slot_q == SL_LAST) ? '0 : slot_q + 1'b1;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            sync1_q  <= 2'b00;
            sync2_q  <= 2'b00;
            sync3_q  <= 2'b00;
            symbol_q <= 1'b0;
            valid_q  <= 1'b0;
            run_q    <= '0;
            phase_q  <= '0;
            slot_q   <= '0;
            tick_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            sync3_q  <= sync3_d;
            symbol_q <= symbol_d;
            valid_q  <= valid_d;
            run_q    <= run_d;
            phase_q  <= phase_d;
            slot_q   <= slot_d;
            tick_q   <= tick_d;
        end
    end

    assign symbol       = symbol_q;
    assign symbol_valid = valid_q;
    assign run_len      = run_q;
    assign tick         = tick_q;

endmodule
`default_nettype wire

// File: rtl/axis_mil1553_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : axis_mil1553_decoder
//  Description : MIL-STD-1553 Manchester II receiver. Hunts for the 3-bit
//                sync, decodes 16 data bits plus odd parity and presents each
//                word on an AXI-Stream master with sync type and parity status.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_mil1553_decoder #(
    parameter int CLOCK_SPEED = 100_000_000,
    parameter int SAMPLE_RATE = 2_000_000
) (
    input  logic        aclk,
    input  logic        arstn,
    input  logic [1:0]  diff,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic [7:0]  m_axis_tuser,
    input  logic        m_axis_tready
);
    import mil1553_pkg::*;

    localparam int HB_CLK = hb_of(CLOCK_SPEED);
    localparam int SMIN   = sync_min_of(HB_CLK);
    localparam int SMAX   = sync_max_of(HB_CLK);
    localparam int RUN_W  = $clog2(SMAX + 2);

    localparam logic [RUN_W-1:0] RUN_MIN = RUN_W'(SMIN);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(SMAX);

    logic             sym;
    logic             sym_valid;
    logic [RUN_W-1:0] run_len;
    logic             tick;

    mil1553_bit_sampler #(
        .CLOCK_SPEED (CLOCK_SPEED),
        .SAMPLE_RATE (SAMPLE_RATE),
        .RUN_W       (RUN_W)
    ) u_sampler (
        .aclk         (aclk),
        .arstn        (arstn),
        .diff         (diff),
        .symbol       (sym),
        .symbol_valid (sym_valid),
        .run_len      (run_len),
        .tick         (tick)
    );

    dec_state_t  state_q, state_d;
    logic [2:0]  sync_type_q, sync_type_d;
    logic [1:0]  tick_cnt_q, tick_cnt_d;
    logic        half_q, half_d;
    logic        first_q, first_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [16:0] shift_q, shift_d;
    logic [15:0] tdata_q, tdata_d;
    logic [7:0]  tuser_q, tuser_d;
    logic        tvalid_q, tvalid_d;

    // A fresh valid level has just appeared on the bus
    wire w_new_level = sym_valid && (run_len == '0);

    // Next-state: sync hunt, bit decode and output register update
    always_comb begin
        state_d     = state_q;
        sync_type_d = sync_type_q;
        tick_cnt_d  = tick_cnt_q;
        half_d      = half_q;
        first_d     = first_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tdata_d     = tdata_q;
        tuser_d     = tuser_q;
        tvalid_d    = tvalid_q;

        if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (sym_valid && (run_len >= RUN_MIN)) begin
                    state_d     = ST_SYNC1;
                    sync_type_d = sym ? SYNC_CMD : SYNC_DATA;
                end
            end
            ST_SYNC1: begin
                if (!sym_valid) begin
                    state_d = ST_IDLE;
                end else if (w_new_level) begin
                    state_d    = ST_SYNC2;
                    tick_cnt_d = 2'd0;
                end else if (run_len > RUN_MAX) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SYNC2: begin
                // Any transition before the third centre tick means a short second half
                if (!sym_valid || w_new_level) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (tick_cnt_q == 2'd2) begin
                        state_d   = ST_DATA;
                        half_d    = 1'b0;
                        bit_cnt_d = 5'd0;
                        shift_d   = 17'd0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 2'd1;
                    end
                end
            end
            ST_DATA: begin
                if (!sym_valid) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (!half_q) begin
                        first_d = sym;
                        half_d  = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        if (sym == first_q) begin
                            state_d = ST_IDLE;
                        end else begin
                            shift_d = {shift_q[15:0], first_q};
                            if (bit_cnt_q == 5'd16) begin
                                state_d = ST_OUT;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 5'd1;
                            end
                        end
                    end
                end
            end
            ST_OUT: begin
                // Overwrites any unaccepted word; tvalid stays high
                tdata_d                                = shift_q[16:1];
                tuser_d                                = 8'h00;
                tuser_d[TUSER_SYNC_MSB:TUSER_SYNC_LSB] = sync_type_q;
                tuser_d[TUSER_PARITY]                  = ^shift_q;
                tvalid_d                               = 1'b1;
                state_d                                = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q     <= ST_IDLE;
            sync_type_q <= 3'b000;
            tick_cnt_q  <= 2'd0;
            half_q      <= 1'b0;
            first_q     <= 1'b0;
            bit_cnt_q   <= 5'd0;
            shift_q     <= 17'd0;
            tdata_q     <= 16'h0000;
            tuser_q     <= 8'h00;
            tvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_type_q <= sync_type_d;
            tick_cnt_q  <= tick_cnt_d;
            half_q      <= half_d;
            first_q     <= first_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tdata_q     <= tdata_d;
            tuser_q     <= tuser_d;
            tvalid_q    <= tvalid_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tvalid = tvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_mil1553_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_mil1553_decoder
//  Description : Self-checking bench for axis_mil1553_decoder. An ideal
//                1 Mbit/s Manchester encoder drives the bus; expected beats
//                are derived from the word contents and the odd-parity rule.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_mil1553_decoder;
    import mil1553_pkg::*;

    localparam int HBC = HB;

    logic        aclk   = 1'b0;
    logic        arstn  = 1'b0;
    logic [1:0]  diff   = 2'b00;
    logic        tready = 1'b1;
    logic [15:0] tdata;
    logic        tvalid;
    logic [7:0]  tuser;

    int vectors     = 0;
    int miscompares = 0;

    logic [23:0] exp_q[$];
    logic [23:0] rx_q[$];

    logic        cmd;
    logic [15:0] data;
    logic        par;

    always #5 aclk = ~aclk;

    axis_mil1553_decoder #(
        .CLOCK_SPEED (100_000_000),
        .SAMPLE_RATE (2_000_000)
    ) dut (
        .aclk          (aclk),
        .arstn         (arstn),
        .diff          (diff),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tuser  (tuser),
        .m_axis_tready (tready)
    );

    // Capture every accepted beat
    always @(negedge aclk) begin
        if (arstn && tvalid && tready) rx_q.push_back({tuser, tdata});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        diff = 2'b00;
        repeat (n) @(negedge aclk);
    endtask

    task automatic level(input logic lvl, input int halves);
        diff = {lvl, ~lvl};
        repeat (halves * HBC) @(negedge aclk);
    endtask

    // bad >= 0 forces data bit 'bad' to equal halves (1,1)
    task automatic send_word(input logic c, input logic [15:0] d, input logic p, input int bad);
        logic [16:0] w;
        w = {d, p};
        level(c, 3);
        level(~c, 3);
        for (int i = 16; i >= 0; i--) begin
            if (bad >= 0 && i == bad + 1) begin
                level(1'b1, 2);
            end else begin
                level(w[i], 1);
                level(~w[i], 1);
            end
        end
    endtask

    // Reference: what a correct receiver reports for a cleanly received word
    task automatic expect_word(input logic c, input logic [15:0] d, input logic p);
        logic [2:0] st;
        logic       good;
        st   = c ? 3'b100 : 3'b010;
        good = ((($countones(d) + int'(p)) % 2) == 1);
        exp_q.push_back({st, 4'b0000, good, d});
    endtask

    task automatic check_beats(input string tag);
        int n;
        check($sformatf("%s count", tag), rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s beat%0d", tag, i), rx_q[i], exp_q[i]);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        repeat (5) @(negedge aclk);
        check("rst tvalid", tvalid, 0);
        check("rst tdata", tdata, 0);
        check("rst tuser", tuser, 0);
        arstn = 1'b1;
        idle(200);

        // Command sync, zero data
        expect_word(1'b1, 16'h0000, 1'b1);
        send_word(1'b1, 16'h0000, 1'b1, -1);
        idle(300);
        check_beats("t1");
        check("t1 tuser", tuser, 32'h81);

        // Data sync, alternating pattern
        expect_word(1'b0, 16'hA5A5, 1'b1);
        send_word(1'b0, 16'hA5A5, 1'b1, -1);
        idle(300);
        check_beats("t2");
        check("t2 tuser", tuser, 32'h41);

        // Counting words back-to-back, alternating sync
        for (int i = 0; i < 17; i++) begin
            cmd  = (i % 2 == 0);
            data = 16'(i);
            par  = ~^data;
            expect_word(cmd, data, par);
            send_word(cmd, data, par, -1);
        end
        idle(300);
        check_beats("t3");

        // Random words back-to-back with random parity
        for (int i = 0; i < 5; i++) begin
            cmd  = 1'($urandom_range(0, 1));
            data = 16'($urandom);
            par  = 1'($urandom_range(0, 1));
            expect_word(cmd, data, par);
            send_word(cmd, data, par, -1);
        end
        idle(300);
        check_beats("rnd");

        // Parity bad and parity good versions of 0x1234
        expect_word(1'b1, 16'h1234, 1'b1);
        send_word(1'b1, 16'h1234, 1'b1, -1);
        idle(300);
        check_beats("t4 bad par");
        check("t4 tuser bad", tuser, 32'h80);
        expect_word(1'b1, 16'h1234, 1'b0);
        send_word(1'b1, 16'h1234, 1'b0, -1);
        idle(300);
        check_beats("t4 good par");

        // Manchester error drops the word; next word decodes
        send_word(1'b0, 16'h5A5A, 1'b1, 7);
        idle(300);
        expect_word(1'b1, 16'h00FF, 1'b1);
        send_word(1'b1, 16'h00FF, 1'b1, -1);
        idle(300);
        check_beats("t4 manch");

        // Back-pressure across a whole word
        @(posedge aclk); #1 tready = 1'b0;
        data = 16'hBEEF;
        par  = ~^data;
        send_word(1'b1, data, par, -1);
        idle(100);
        check("t5 tvalid held", tvalid, 1);
        check("t5 tdata held", tdata, 32'hBEEF);
        idle(1000);
        check("t5 tvalid still", tvalid, 1);
        check("t5 tdata still", tdata, 32'hBEEF);
        check("t5 tuser still", tuser, 32'h81);
        check("t5 no beat yet", rx_q.size(), 0);
        expect_word(1'b1, data, par);
        @(posedge aclk); #1 tready = 1'b1;
        repeat (3) @(negedge aclk);
        check_beats("t5 hold");
        check("t5 tvalid drop", tvalid, 0);

        // Reset mid-word discards held and partial words
        @(posedge aclk); #1 tready = 1'b0;
        send_word(1'b0, 16'h0F0F, 1'b1, -1);
        idle(100);
        check("t5 pre-rst tvalid", tvalid, 1);
        fork
            send_word(1'b1, 16'h3C3C, 1'b1, -1);
            begin
                repeat (1000) @(negedge aclk);
                #2 arstn = 1'b0;
                #1;
                check("t5 rst tvalid", tvalid, 0);
                check("t5 rst tdata", tdata, 0);
                check("t5 rst tuser", tuser, 0);
                repeat (3) @(negedge aclk);
                #2 arstn = 1'b1;
            end
        join
        idle(300);
        @(posedge aclk); #1 tready = 1'b1;
        repeat (5) @(negedge aclk);
        check_beats("t5 rst");
        check("t5 rst no tvalid", tvalid, 0);

        // Fresh word decodes after reset
        expect_word(1'b0, 16'hC3C3, 1'b1);
        send_word(1'b0, 16'hC3C3, 1'b1, -1);
        idle(300);
        check_beats("post rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
